instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Program-counter and fetch sequencer directly upstream of the control decoder.
//   Drives instruction-ROM address; registers the returned 9-bit word as mach_code.
//   Redirects the PC through an 8-entry jump LUT (indexed by 3-bit jptr) on a taken jump.
//   Runs a start/done handshake; the top-level testbench uses it to launch and finish programs.
// PARAMETERS
//   PC_W       10      PC / instruction-ROM address width
//   START_PC   0       PC loaded on each start
//   NOP_CODE   9'h00F  bubble word (opcode 4'b1111: no reg or mem write)
//   HALT_CODE  9'h1FF  word that ends program execution
// PORTS
//   clk         in   1     single clock, all state on posedge
//   reset_n     in   1     synchronous reset, active low
//   start       in   1     level; launches program from IDLE or DONE
//   stall       in   1     hold PC and mach_code this cycle (multi-cycle LD)
//   jump_take   in   1     decoder says current mach_code is a taken jump
//   jptr        in   3     jump LUT index for current mach_code
//   lut_we      in   1     jump LUT write enable
//   lut_idx     in   3     jump LUT write index
//   lut_data    in   PC_W  jump LUT write data
//   imem_data   in   9     combinational ROM read data at imem_addr
//   imem_addr   out  PC_W  = pc
//   mach_code   out  9     registered instruction to decoder
//   busy        out  1     high in RUN
//   done        out  1     high in DONE
// BEHAVIOUR
//   Reset (reset_n=0 at posedge), including mid-run:
//   - state=IDLE, pc=0, mach_code=NOP_CODE, all LUT entries=0, busy=0, done=0.
//   FSM states IDLE, RUN, DONE:
//   - IDLE: start=1 -> RUN; pc<=START_PC; mach_code<=NOP_CODE.
//   - RUN, stall=1: pc and mach_code hold; jump and halt are deferred, not dropped.
//   - RUN, stall=0, mach_code==HALT_CODE -> DONE; pc and mach_code hold.
//   - RUN, stall=0, jump_take=1: pc<=LUT[jptr]; mach_code<=NOP_CODE.
//     One-bubble flush; the word fetched at pc is discarded.
//   - RUN, otherwise: mach_code<=imem_data; pc<=pc+1.
//   - DONE: done=1, pc and mach_code hold. start=1 restarts exactly as from IDLE.
//     done falls the same edge.
//   Priority in RUN: stall > halt > jump > sequential.
//   Latency: word at address A appears on mach_code 1 clk after pc==A (no stall).
//   Jump penalty is 1 bubble cycle.
//   PC arithmetic: unsigned PC_W bits; pc+1 wraps from 2^PC_W-1 to 0 with no flag.
//   Jump LUT:
//   - lut_we writes LUT[lut_idx]<=lut_data in any state.
//   - Same-cycle write and jump to the same index reads the OLD entry.
//   jump_take and jptr are ignored outside RUN.
//   busy and done are registered state decodes, never both high.
// TESTING
//   1. Reset then start=1, ROM[0..3]=9'h001,9'h002,9'h003,9'h1FF.
//      -> mach_code 00F,001,002,003,1FF on successive clks.
//      -> done=1 the cycle after 1FF is seen; pc held at 4.
//   2. LUT[5]=10'd20; jump_take=1, jptr=5 while pc=7.
//      -> next pc=20, mach_code=00F.
//      -> next clk mach_code=ROM[20], pc=21.
//   3. stall=1 for 3 clks with mach_code=002, pc=3 -> both unchanged.
//      Then stall=0 -> mach_code=ROM[3], pc=4.
//   4. PC_W=4, run to pc=15 -> next pc=0, mach_code=ROM[15]; no error.
//   5. reset_n=0 mid-run at pc=9 -> next clk pc=0, mach_code=00F, IDLE, busy=0.
//      LUT reads back 0.
//   6. In DONE, start=1 -> pc=START_PC, done=0, busy=1, program replays identically.
//      Also cover same-cycle lut_we to idx 2 with jptr=2 jump -> old LUT[2] used.

Source files
------------

// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer: drives the instruction-ROM address, registers the
// returned word for the decoder, redirects through an 8-entry jump LUT, runs start/done.
module instr_fetch #(
    parameter int unsigned     PC_W      = 10,
    parameter logic [PC_W-1:0] START_PC  = '0,
    parameter logic [8:0]      NOP_CODE  = 9'h00F,
    parameter logic [8:0]      HALT_CODE = 9'h1FF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stall,
    input  logic            jump_take,
    input  logic [2:0]      jptr,
    input  logic            lut_we,
    input  logic [2:0]      lut_idx,
    input  logic [PC_W-1:0] lut_data,
    input  logic [8:0]      imem_data,
    output logic [PC_W-1:0] imem_addr,
    output logic [8:0]      mach_code,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [8:0]      mc_q;
    logic            busy_q;
    logic            done_q;
    logic [PC_W-1:0] lut_q [8];

    localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            mc_q    <= NOP_CODE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        pc_q    <= START_PC;
                        mc_q    <= NOP_CODE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StRun: begin
                    // A stall freezes everything, so a pending halt or jump is retried later.
                    if (!stall) begin
                        if (mc_q == HALT_CODE) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (jump_take) begin
                            pc_q <= lut_q[jptr];
                            mc_q <= NOP_CODE;
                        end else begin
                            mc_q <= imem_data;
                            pc_q <= pc_q + PcOne;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Non-blocking write means a same-cycle jump through this index sees the old entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_idx] <= lut_data;
        end
    end

    assign imem_addr = pc_q;
    assign mach_code = mc_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
